// File: rtl/vectadd_nios2_qsys_0_oci_dct_packer_if.sv
// Handshake bundle between the trace-code source, the DCT packer and the trace FIFO side.
// The slave modport is the packer's view; master is the environment driving it.
interface vectadd_nios2_qsys_0_oci_dct_packer_if #(
  parameter int CODES = 15,
  parameter int CNT_W = 4
);
  logic                 code_valid;
  logic [1:0]           code;
  logic                 code_ready;
  logic                 flush;
  logic [2*CODES-1:0]   dct_buffer;
  logic [CNT_W-1:0]     dct_count;
  logic                 pkt_valid;
  logic                 pkt_ready;
  logic [2*CODES-1:0]   pkt_buffer;
  logic [CNT_W-1:0]     pkt_count;
  logic                 flush_pending;

  modport slave (
    input  code_valid, code, flush, pkt_ready,
    output code_ready, dct_buffer, dct_count, pkt_valid, pkt_buffer, pkt_count, flush_pending
  );

  modport master (
    output code_valid, code, flush, pkt_ready,
    input  code_ready, dct_buffer, dct_count, pkt_valid, pkt_buffer, pkt_count, flush_pending
  );
endinterface

// File: rtl/vectadd_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit trace codes into up-to-15-code packets and hands them to a
// one-entry valid/ready output register; flushes emit partial packets.
module vectadd_nios2_qsys_0_oci_dct_packer #(
  parameter int CODES = 15,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic reset,
  vectadd_nios2_qsys_0_oci_dct_packer_if.slave bus
);
  localparam int W = 2 * CODES;

  logic [W-1:0]     acc_buf;
  logic [CNT_W-1:0] acc_cnt;
  logic             pkt_vld;
  logic [W-1:0]     pkt_buf;
  logic [CNT_W-1:0] pkt_cnt;
  logic             flush_pnd;

  logic slot_free, flush_req, full, nonempty, want_emit, emit, rdy, accept;

  always_comb begin
    slot_free = !pkt_vld || bus.pkt_ready;
    flush_req = bus.flush || flush_pnd;
    full      = (acc_cnt == CNT_W'(CODES));
    nonempty  = (acc_cnt != '0);
    want_emit = full || (flush_req && nonempty);
    emit      = slot_free && want_emit;
    // a packet that wants out but has nowhere to go blocks the input
    rdy       = !(want_emit && !slot_free);
    accept    = bus.code_valid && rdy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_buf   <= '0;
      acc_cnt   <= '0;
      pkt_vld   <= 1'b0;
      pkt_buf   <= '0;
      pkt_cnt   <= '0;
      flush_pnd <= 1'b0;
    end else begin
      if (emit) begin
        pkt_buf <= acc_buf;
        pkt_cnt <= acc_cnt;
        pkt_vld <= 1'b1;
        // the code accepted alongside an emit starts the next packet
        acc_buf <= accept ? {{(W-2){1'b0}}, bus.code} : '0;
        acc_cnt <= accept ? CNT_W'(1) : '0;
      end else begin
        if (accept) begin
          acc_buf <= {acc_buf[W-3:0], bus.code};
          acc_cnt <= acc_cnt + CNT_W'(1);
        end
        if (pkt_vld && bus.pkt_ready)
          pkt_vld <= 1'b0;
      end

      if (emit)
        flush_pnd <= 1'b0;
      else if (bus.flush && nonempty && !slot_free)
        flush_pnd <= 1'b1;
    end
  end

  assign bus.code_ready    = rdy;
  assign bus.dct_buffer    = acc_buf;
  assign bus.dct_count     = acc_cnt;
  assign bus.pkt_valid     = pkt_vld;
  assign bus.pkt_buffer    = pkt_buf;
  assign bus.pkt_count     = pkt_cnt;
  assign bus.flush_pending = flush_pnd;
endmodule

// File: tb/tb_vectadd_nios2_qsys_0_oci_dct_packer.sv
// Directed bench for the DCT packer: full packets, flushes, stalls and reset.
module tb_vectadd_nios2_qsys_0_oci_dct_packer;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  vectadd_nios2_qsys_0_oci_dct_packer_if #(.CODES(15), .CNT_W(4)) bus();

  vectadd_nios2_qsys_0_oci_dct_packer #(.CODES(15), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [1:0] c);
    bus.code_valid = 1'b1;
    bus.code       = c;
    tick();
    bus.code_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dbuf"}, 32'(bus.dct_buffer), 32'h0);
    chk({tag, "_dcnt"}, 32'(bus.dct_count), 32'h0);
    chk({tag, "_pvld"}, 32'(bus.pkt_valid), 32'h0);
    chk({tag, "_pbuf"}, 32'(bus.pkt_buffer), 32'h0);
    chk({tag, "_pcnt"}, 32'(bus.pkt_count), 32'h0);
    chk({tag, "_fpnd"}, 32'(bus.flush_pending), 32'h0);
    chk({tag, "_crdy"}, 32'(bus.code_ready), 32'h1);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.code_valid = 1'b0;
    bus.code = 2'b00;
    bus.flush = 1'b0;
    bus.pkt_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_zero("rst");

    // 15 x code 01 back-to-back
    for (int i = 0; i < 15; i++) feed(2'b01);
    chk("full_dcnt", 32'(bus.dct_count), 32'd15);
    chk("full_dbuf", 32'(bus.dct_buffer), 32'h15555555);
    chk("full_pvld0", 32'(bus.pkt_valid), 32'h0);
    chk("full_crdy", 32'(bus.code_ready), 32'h1);
    tick();
    chk("full_pvld", 32'(bus.pkt_valid), 32'h1);
    chk("full_pbuf", 32'(bus.pkt_buffer), 32'h15555555);
    chk("full_pcnt", 32'(bus.pkt_count), 32'd15);
    chk("full_dcnt0", 32'(bus.dct_count), 32'd0);
    tick();
    chk("full_pop", 32'(bus.pkt_valid), 32'h0);

    // 3,2,1 then flush
    feed(2'd3); feed(2'd2); feed(2'd1);
    chk("fl_dbuf", 32'(bus.dct_buffer), 32'h39);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fl_pvld", 32'(bus.pkt_valid), 32'h1);
    chk("fl_pbuf", 32'(bus.pkt_buffer), 32'h39);
    chk("fl_pcnt", 32'(bus.pkt_count), 32'd3);
    chk("fl_dbuf0", 32'(bus.dct_buffer), 32'h0);
    chk("fl_dcnt0", 32'(bus.dct_count), 32'd0);
    tick();
    chk("fl_pop", 32'(bus.pkt_valid), 32'h0);

    // flush on empty accumulator does nothing
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fle_pvld", 32'(bus.pkt_valid), 32'h0);
    chk("fle_fpnd", 32'(bus.flush_pending), 32'h0);
    tick();
    chk("fle_pvld2", 32'(bus.pkt_valid), 32'h0);

    // stall: one packet held, 15 more codes, then release
    for (int i = 0; i < 15; i++) feed(2'b10);
    tick();
    chk("st_pbuf0", 32'(bus.pkt_buffer), 32'h2AAAAAAA);
    bus.pkt_ready = 1'b0;
    for (int i = 0; i < 15; i++) feed(2'b11);
    chk("st_dcnt", 32'(bus.dct_count), 32'd15);
    chk("st_dbuf", 32'(bus.dct_buffer), 32'h3FFFFFFF);
    bus.code_valid = 1'b1;
    bus.code = 2'b01;
    #1;
    chk("st_crdy0", 32'(bus.code_ready), 32'h0);
    tick();
    chk("st_hold_dcnt", 32'(bus.dct_count), 32'd15);
    chk("st_hold_pbuf", 32'(bus.pkt_buffer), 32'h2AAAAAAA);
    chk("st_hold_pvld", 32'(bus.pkt_valid), 32'h1);
    bus.pkt_ready = 1'b1;
    #1;
    chk("st_crdy1", 32'(bus.code_ready), 32'h1);
    tick();
    bus.code_valid = 1'b0;
    chk("st_pvld", 32'(bus.pkt_valid), 32'h1);
    chk("st_pbuf", 32'(bus.pkt_buffer), 32'h3FFFFFFF);
    chk("st_pcnt", 32'(bus.pkt_count), 32'd15);
    chk("st_dcnt1", 32'(bus.dct_count), 32'd1);
    chk("st_dbuf1", 32'(bus.dct_buffer), 32'h1);
    tick();
    chk("st_pop", 32'(bus.pkt_valid), 32'h0);

    // flush while stalled with 5 codes
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fs_p1buf", 32'(bus.pkt_buffer), 32'h1);
    chk("fs_p1cnt", 32'(bus.pkt_count), 32'd1);
    bus.pkt_ready = 1'b0;
    feed(2'd0); feed(2'd1); feed(2'd2); feed(2'd3); feed(2'd0);
    chk("fs_dcnt5", 32'(bus.dct_count), 32'd5);
    chk("fs_dbuf5", 32'(bus.dct_buffer), 32'h6C);
    bus.flush = 1'b1;
    #1;
    chk("fs_crdy_fl", 32'(bus.code_ready), 32'h0);
    tick();
    bus.flush = 1'b0;
    chk("fs_fpnd", 32'(bus.flush_pending), 32'h1);
    bus.code_valid = 1'b1;
    bus.code = 2'd3;
    #1;
    chk("fs_crdy_pnd", 32'(bus.code_ready), 32'h0);
    tick();
    chk("fs_nodrop_dcnt", 32'(bus.dct_count), 32'd5);
    chk("fs_hold_pbuf", 32'(bus.pkt_buffer), 32'h1);
    bus.pkt_ready = 1'b1;
    tick();
    bus.code_valid = 1'b0;
    chk("fs_pbuf", 32'(bus.pkt_buffer), 32'h6C);
    chk("fs_pcnt", 32'(bus.pkt_count), 32'd5);
    chk("fs_fpnd0", 32'(bus.flush_pending), 32'h0);
    chk("fs_dcnt1", 32'(bus.dct_count), 32'd1);
    chk("fs_dbuf1", 32'(bus.dct_buffer), 32'h3);

    // reset with a partial accumulator and a held packet
    bus.pkt_ready = 1'b0;
    for (int i = 0; i < 6; i++) feed(2'b01);
    chk("rs_dcnt7", 32'(bus.dct_count), 32'd7);
    chk("rs_pvld1", 32'(bus.pkt_valid), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero("rs");
    bus.pkt_ready = 1'b1;
    feed(2'd2); feed(2'd1);
    chk("rs_dbuf", 32'(bus.dct_buffer), 32'h9);
    chk("rs_dcnt", 32'(bus.dct_count), 32'd2);
    chk("rs_pvld", 32'(bus.pkt_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vectadd_nios2_qsys_0_oci_dct_packer.md
Name: vectadd_nios2_qsys_0_oci_dct_packer

Overview:
Upstream data-trace packing stage for the Nios II OCI.
- Accepts 2-bit trace codes one per cycle and packs them into a 30-bit buffer of up to 15 codes.
- Exposes the live buffer and fill level as dct_buffer/dct_count; these feed the OCI test bench and trace monitor.
- Emits full or flushed packets through a one-entry valid/ready output register toward the trace FIFO.

Parameters:
- CODES, 15, codes per packet; buffer width is 2*CODES and must equal 30.
- CNT_W, 4, width of count fields; must satisfy 2^CNT_W > CODES.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- code_valid  in  1  trace code offered.
- code  in  2  trace code value.
- code_ready  out  1  code accepted this cycle when code_valid && code_ready.
- flush  in  1  single-cycle pulse: emit the partial buffer.
- dct_buffer  out  30  live accumulator; newest code in [1:0]; unfilled upper bits 0.
- dct_count  out  4  live number of codes in the accumulator, 0..15.
- pkt_valid  out  1  output packet held.
- pkt_ready  in  1  consumer takes the packet when pkt_valid && pkt_ready.
- pkt_buffer  out  30  packet payload, same layout as dct_buffer.
- pkt_count  out  4  codes in packet, 1..15.
- flush_pending  out  1  a flush is latched and not yet served.

Behaviour:
- Reset (sync, overrides everything):
  - dct_buffer=0, dct_count=0, pkt_valid=0, pkt_buffer=0, pkt_count=0, flush_pending=0.
  - code_ready is combinational and reads 1 after reset.
  - Reset mid-packet discards the accumulator and the held packet with no emission.
- Definitions:
  - slot_free = !pkt_valid || pkt_ready.
  - flush_req = flush || flush_pending.
  - emit = slot_free && ((dct_count==15) || (flush_req && dct_count!=0)).
- code_ready (combinational): 0 when (dct_count==15 && !slot_free) or (flush_req && dct_count!=0 && !slot_free); otherwise 1.
- Accept without emit: dct_buffer <= {dct_buffer[27:0], code}; dct_count += 1.
- Emit:
  - pkt_buffer <= dct_buffer; pkt_count <= dct_count; pkt_valid <= 1.
  - Accumulator clears. If a code is accepted in the same cycle, the accumulator becomes {28'b0, code} with count 1.
  - Zero bubbles across a packet boundary.
- Pop without emit: pkt_valid <= 0. With simultaneous emit, pkt_valid stays 1 and the register reloads.
- Flush handling:
  - flush with dct_count==0 is ignored; flush_pending is not set.
  - flush with dct_count!=0 and !slot_free sets flush_pending.
  - flush_pending clears on emit.
  - flush with dct_count==15 is identical to a normal full emit.
- Latency:
  - 15th code accepted at edge N; dct_count==15 visible after N.
  - pkt_valid asserts after edge N+1 if slot_free in cycle N+1; otherwise the packet waits with code_ready=0.
- Ordering: packets leave in acceptance order. Codes are never dropped or duplicated.
- Counts never exceed 15. No wrap.

Test Plan:
- Stream 15 codes 2'b01 back-to-back, pkt_ready=1 -> one cycle later pkt_valid=1, pkt_buffer=30'h15555555, pkt_count=15; dct_count=0 (or 1 if a 16th code arrived).
- Codes 3,2,1 then flush -> pkt_buffer=30'h39, pkt_count=3; dct_buffer=0, dct_count=0 next cycle.
- Flush with empty accumulator -> no pkt_valid; flush_pending stays 0.
- Hold pkt_ready=0 with one packet held, feed 15 more codes -> code_ready=0 at dct_count=15. Raise pkt_ready -> old packet pops, new packet loads the same cycle, and the new code enters as count 1.
- Flush while the held packet is stalled and dct_count=5 -> flush_pending=1 and code_ready=0 until pkt_ready. Then a 5-code packet is emitted and flush_pending=0.
- Assert reset with dct_count=7 and pkt_valid=1 -> next cycle all outputs 0 and code_ready=1; the following codes pack from an empty accumulator.
